y_wb_buf_vec4: RTL
==================

// Module: y_wb_buf_vec4
// PURPOSE
//  Downstream stage of the output gate (y = s*g). Collects one frame of gated y
//  vectors (TILE_SIZE lanes per beat) into an on-chip buffer. Exposes the buffer
//  to the write-back / next-layer reader through a 1-cycle-latency read port.
//  Signals frame completion with a done pulse.
// PARAMETERS
//  TILE_SIZE  4   lanes per vector beat
//  W          16  lane width (signed fixed-point, passed through unmodified)
//  ADDR_W     6   buffer address width; DEPTH = 2**ADDR_W vector entries
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    asynchronous, active-high reset
//  start      in   1                    begin a frame; sampled only in IDLE
//  frame_len  in   ADDR_W+1             beats in frame; sampled with start
//  abort      in   1                    cancel frame in progress, back to IDLE
//  y_valid    in   1                    gated vector valid (from gate stage)
//  y_ready    out  1                    buffer accepts beat
//  y_vec      in   W x TILE_SIZE        signed gated vector
//  rd_en      in   1                    read request
//  rd_addr    in   ADDR_W               read entry index
//  rd_valid   out  1                    rd_data valid (rd_en delayed 1 cycle)
//  rd_data    out  W x TILE_SIZE        read vector
//  busy       out  1                    high in FILL
//  done       out  1                    1-cycle pulse, frame fully written
//  wr_count   out  ADDR_W+1             beats written in current/last frame
// BEHAVIOUR
//  Reset: FSM=IDLE, y_ready=0, busy=0, done=0, rd_valid=0, wr_count=0, wr_addr=0.
//  rd_data=0. Buffer contents are not cleared.
//  FSM states: IDLE, FILL, DONE.
//   IDLE -> start=1:
//     latch len = min(frame_len, DEPTH); wr_addr=0; wr_count=0.
//     len==0 -> DONE, else -> FILL.
//   FILL: y_ready=1, busy=1. On handshake (y_valid&y_ready):
//     write y_vec to mem[wr_addr]; wr_addr++; wr_count++.
//     Handshake with wr_count==len-1 -> DONE.
//   DONE: done=1 for exactly this cycle, y_ready=0; next cycle -> IDLE.
//  abort: in FILL -> IDLE next cycle. Beat handshaking in the same cycle is still
//   written. No done pulse. wr_count keeps partial value. Ignored in IDLE/DONE.
//  start while FILL/DONE: ignored. start and abort together in IDLE: start wins.
//  y_ready is registered from state only; no combinational y_valid->y_ready path.
//  Upstream stalls are legal at any beat; no beat is dropped or duplicated.
//  Read port: independent of FSM, legal in any state.
//   rd_data/rd_valid registered one cycle after rd_en.
//   rd_valid=0 and rd_data holds its last value when rd_en=0.
//   Same-cycle read and write to the same address returns OLD data (read-first).
//  Lanes stored bit-exact; no rescaling or saturation. Lane i of y_vec maps to
//   lane i of rd_data.
//  Reset asserted mid-frame: immediate return to IDLE, outputs at reset values.
// STRUCTURE
//  Shared package (ssm_pkg): typedef logic signed [W-1:0] vec_t[TILE_SIZE];
//   wb_state_e {IDLE,FILL,DONE}.
//  Sub-module sdp_ram_vec (simple dual-port, 1W/1R, read-first, registered read,
//   TILE_SIZE*W wide, DEPTH deep).
//  Top holds FSM, address/count logic, and the done pulse.
// TESTING
//  1 start, frame_len=4, y_valid held high, y_vec beat k = {k,k+1,k+2,k+3}
//    -> y_ready high 4 cycles; done pulses in the cycle after the 4th handshake;
//       wr_count=4; reads of addr 0..3 return the written vectors one cycle later.
//  2 frame_len=8, y_valid toggled 1,0,1,0...
//    -> exactly 8 entries written in order; done asserted once; y_ready low after.
//  3 frame_len=0 -> DONE next cycle, done pulse, no writes, y_ready never high.
//  4 frame_len=100 with ADDR_W=6 -> clamped to 64 beats; done after the 64th
//    handshake; entry 0 not overwritten.
//  5 abort after 3 of 10 beats (4th beat handshaking in the abort cycle)
//    -> wr_count=4, no done pulse, IDLE; a new start is accepted next cycle.
//  6 rd_addr=2 read in the same cycle mem[2] is written with 0x7FFF lanes
//    -> rd_data returns the old value; next read of addr 2 returns 0x7FFF.
//    Reset asserted mid-FILL -> all outputs take reset values immediately.

Source files
------------

// File: rtl/ssm_pkg.sv
// Shared types and default geometry for the SSM output-gate write-back path.
package ssm_pkg;
   localparam int DEF_TILE_SIZE = 4;
   localparam int DEF_W         = 16;
   localparam int DEF_ADDR_W    = 6;

   typedef logic signed [DEF_W-1:0] vec_t [DEF_TILE_SIZE];
   typedef enum logic [1:0] {IDLE, FILL, DONE} wb_state_e;
endpackage

// File: rtl/sdp_ram_vec.sv
// Simple dual-port vector RAM: one write port, one registered read-first read port.
module sdp_ram_vec #(
   parameter int TILE_SIZE = 4,
   parameter int W         = 16,
   parameter int ADDR_W    = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [TILE_SIZE-1:0][W-1:0]   wr_data,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic                          rd_valid,
   output logic [TILE_SIZE-1:0][W-1:0]   rd_data
);
   localparam int DEPTH = 2**ADDR_W;

   logic [TILE_SIZE-1:0][W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   // Non-blocking read of mem in the same edge as a write yields the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/y_wb_buf_vec4.sv
// Frame collector for gated y vectors: fills an on-chip buffer, pulses done,
// and serves a 1-cycle-latency read port to the write-back reader.
module y_wb_buf_vec4
   import ssm_pkg::*;
#(
   parameter int TILE_SIZE = DEF_TILE_SIZE,
   parameter int W         = DEF_W,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_W:0]               frame_len,
   input  logic                          abort,
   input  logic                          y_valid,
   output logic                          y_ready,
   input  logic [TILE_SIZE-1:0][W-1:0]   y_vec,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic                          rd_valid,
   output logic [TILE_SIZE-1:0][W-1:0]   rd_data,
   output logic                          busy,
   output logic                          done,
   output logic [ADDR_W:0]               wr_count
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);

   wb_state_e         state;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W-1:0] wr_addr;
   logic              hs;
   logic              last_beat;

   assign hs        = y_valid & y_ready;
   assign last_beat = (wr_count + (ADDR_W+1)'(1)) == len_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         y_ready  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_count <= '0;
         wr_addr  <= '0;
         len_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  len_q    <= (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
                  wr_addr  <= '0;
                  wr_count <= '0;
                  if (frame_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= FILL;
                     y_ready <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (hs) begin
                  wr_addr  <= wr_addr + 1'b1;
                  wr_count <= wr_count + 1'b1;
               end
               // Abort beats a coincident final handshake: the beat lands but no done.
               if (abort) begin
                  state   <= IDLE;
                  y_ready <= 1'b0;
                  busy    <= 1'b0;
               end else if (hs && last_beat) begin
                  state   <= DONE;
                  y_ready <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sdp_ram_vec #(.TILE_SIZE(TILE_SIZE), .W(W), .ADDR_W(ADDR_W)) u_ram (
      .clk      (clk),
      .rst      (rst),
      .we       (hs),
      .wr_addr  (wr_addr),
      .wr_data  (y_vec),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_valid (rd_valid),
      .rd_data  (rd_data)
   );
endmodule
